// File: rtl/uart_ctrl_if.sv
// Byte-side and serial-line signals of uart_ctrl, bundled for port connection.
// The master drives requests and the RX pin. The slave (the controller) drives status and the TX pin.
interface uart_ctrl_if;
  logic       i_Tx_Ready;
  logic [7:0] i_Tx_Byte;
  logic       o_Tx_Active;
  logic       o_Tx_Data;
  logic       o_Tx_Done;
  logic       i_Rx_Data;
  logic       o_Rx_Done;
  logic [7:0] o_Rx_Byte;

  modport master (
    output i_Tx_Ready, i_Tx_Byte, i_Rx_Data,
    input  o_Tx_Active, o_Tx_Data, o_Tx_Done, o_Rx_Done, o_Rx_Byte
  );

  modport slave (
    input  i_Tx_Ready, i_Tx_Byte, i_Rx_Data,
    output o_Tx_Active, o_Tx_Data, o_Tx_Done, o_Rx_Done, o_Rx_Byte
  );
endinterface

// File: rtl/uart_ctrl.sv
// 8N1 UART: a bit-timed transmitter and a 16x oversampling receiver with an optional internal loopback.
// reset_n is a synchronous reset that is active HIGH, despite its name.
module uart_ctrl #(
  parameter int CLOCK_RATE    = 25000000,
  parameter int BAUD_RATE     = 115200,
  parameter int RX_OVERSAMPLE = 16,
  parameter bit LOOPBACK      = 1'b1
) (
  input logic        clk,
  input logic        reset_n,
  uart_ctrl_if.slave bus
);

  localparam int CLKS_PER_BIT = CLOCK_RATE / BAUD_RATE;
  localparam int TICK_DIV     = CLOCK_RATE / (BAUD_RATE * RX_OVERSAMPLE);
  localparam int BIT_CNT_W    = $clog2(CLKS_PER_BIT);
  localparam int DIV_W        = $clog2(TICK_DIV);
  localparam int OVS_W        = $clog2(RX_OVERSAMPLE);

  localparam logic [BIT_CNT_W-1:0] BIT_LAST     = BIT_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_CNT_W-1:0] BIT_PRE_LAST = BIT_CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [DIV_W-1:0]     DIV_LAST     = DIV_W'(TICK_DIV - 1);
  localparam logic [OVS_W-1:0]     OVS_LAST     = OVS_W'(RX_OVERSAMPLE - 1);
  localparam logic [OVS_W-1:0]     OVS_MID      = OVS_W'(RX_OVERSAMPLE / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_e;

  tx_state_e            tx_state_q;
  logic [BIT_CNT_W-1:0] tx_cnt_q;
  logic [2:0]           tx_bit_q;
  logic [7:0]           tx_shift_q;
  logic                 tx_line_q;
  logic                 tx_active_q;
  logic                 tx_done_q;

  // NOTE: every register here is updated with <= so all flops sample the pre-edge state together.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      tx_state_q  <= TX_IDLE;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_shift_q  <= '0;
      tx_line_q   <= 1'b1;
      tx_active_q <= 1'b0;
      tx_done_q   <= 1'b0;
    end else begin
      tx_done_q <= 1'b0;
      case (tx_state_q)
        TX_IDLE: if (bus.i_Tx_Ready) begin
          tx_shift_q  <= bus.i_Tx_Byte;
          tx_line_q   <= 1'b0;
          tx_active_q <= 1'b1;
          tx_cnt_q    <= '0;
          tx_state_q  <= TX_START;
        end
        TX_START: if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_q   <= '0;
          tx_line_q  <= tx_shift_q[0];
          tx_shift_q <= tx_shift_q >> 1;
          tx_bit_q   <= '0;
          tx_state_q <= TX_DATA;
        end else begin
          tx_cnt_q <= tx_cnt_q + 1'b1;
        end
        TX_DATA: if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_q <= '0;
          if (tx_bit_q == 3'd7) begin
            tx_line_q  <= 1'b1;
            tx_state_q <= TX_STOP;
          end else begin
            tx_line_q  <= tx_shift_q[0];
            tx_shift_q <= tx_shift_q >> 1;
            tx_bit_q   <= tx_bit_q + 1'b1;
          end
        end else begin
          tx_cnt_q <= tx_cnt_q + 1'b1;
        end
        TX_STOP: if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_q    <= '0;
          tx_active_q <= 1'b0;
          tx_state_q  <= TX_IDLE;
        end else begin
          tx_cnt_q <= tx_cnt_q + 1'b1;
          // Raised one clk early so the registered pulse lands on the final stop-bit clk.
          if (tx_cnt_q == BIT_PRE_LAST) tx_done_q <= 1'b1;
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

  rx_state_e        rx_state_q;
  logic [1:0]       rx_sync_q;
  logic [DIV_W-1:0] rx_div_q;
  logic [OVS_W-1:0] rx_ovs_q;
  logic [2:0]       rx_bit_q;
  logic [7:0]       rx_shift_q;
  logic [7:0]       rx_byte_q;
  logic             rx_done_q;
  logic             rx_line;
  logic             rx_tick;

  assign rx_line = LOOPBACK ? tx_line_q : rx_sync_q[1];
  assign rx_tick = (rx_div_q == DIV_LAST);

  always_ff @(posedge clk) begin
    if (reset_n) begin
      rx_state_q <= RX_IDLE;
      // NOTE: synchronizer resets to the idle line level so leaving reset cannot fake a start bit.
      rx_sync_q  <= 2'b11;
      rx_div_q   <= '0;
      rx_ovs_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_byte_q  <= '0;
      rx_done_q  <= 1'b0;
    end else begin
      rx_done_q <= 1'b0;
      rx_sync_q <= {rx_sync_q[0], bus.i_Rx_Data};
      rx_div_q  <= rx_tick ? '0 : rx_div_q + 1'b1;
      case (rx_state_q)
        RX_IDLE: if (!rx_line) begin
          rx_div_q   <= '0;
          rx_ovs_q   <= '0;
          rx_state_q <= RX_START;
        end
        RX_START: if (rx_tick) begin
          if (rx_ovs_q == OVS_MID) begin
            rx_ovs_q   <= '0;
            rx_bit_q   <= '0;
            rx_state_q <= rx_line ? RX_IDLE : RX_DATA;
          end else begin
            rx_ovs_q <= rx_ovs_q + 1'b1;
          end
        end
        RX_DATA: if (rx_tick) begin
          if (rx_ovs_q == OVS_LAST) begin
            rx_ovs_q   <= '0;
            rx_shift_q <= {rx_line, rx_shift_q[7:1]};
            if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
            else                  rx_bit_q   <= rx_bit_q + 1'b1;
          end else begin
            rx_ovs_q <= rx_ovs_q + 1'b1;
          end
        end
        RX_STOP: if (rx_tick) begin
          if (rx_ovs_q == OVS_LAST) begin
            rx_ovs_q <= '0;
            if (rx_line) begin
              rx_byte_q  <= rx_shift_q;
              rx_done_q  <= 1'b1;
              rx_state_q <= RX_IDLE;
            end else begin
              rx_state_q <= RX_WAIT_HIGH;
            end
          end else begin
            rx_ovs_q <= rx_ovs_q + 1'b1;
          end
        end
        RX_WAIT_HIGH: if (rx_line) rx_state_q <= RX_IDLE;
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  assign bus.o_Tx_Active = tx_active_q;
  assign bus.o_Tx_Data   = tx_line_q;
  assign bus.o_Tx_Done   = tx_done_q;
  assign bus.o_Rx_Done   = rx_done_q;
  assign bus.o_Rx_Byte   = rx_byte_q;

endmodule

// File: tb/tb_uart_ctrl.sv
// Directed bench for uart_ctrl: one loopback instance for TX/stream/reset tests and one
// direct-input instance for RX, glitch and framing-error tests.
module tb_uart_ctrl;

  localparam int BIT_CLKS = 217;

  logic clk;
  logic rst_lb;
  logic rst_dir;
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_tx_lb = 0;
  int   n_rx_lb = 0;
  int   n_rx_dir = 0;

  uart_ctrl_if lb_if ();
  uart_ctrl_if dir_if ();

  uart_ctrl #(.LOOPBACK(1'b1)) u_lb  (.clk(clk), .reset_n(rst_lb),  .bus(lb_if));
  uart_ctrl #(.LOOPBACK(1'b0)) u_dir (.clk(clk), .reset_n(rst_dir), .bus(dir_if));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (lb_if.o_Tx_Done === 1'b1)  n_tx_lb++;
    if (lb_if.o_Rx_Done === 1'b1)  n_rx_lb++;
    if (dir_if.o_Rx_Done === 1'b1) n_rx_dir++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_lb_active(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      step(1);
      if (lb_if.o_Tx_Active === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic wait_lb_rx_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      step(1);
      if (lb_if.o_Rx_Done === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic send_dir(input logic [7:0] b, input logic stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      dir_if.i_Rx_Data = bits[i];
      step(BIT_CLKS);
    end
    dir_if.i_Rx_Data = 1'b1;
  endtask

  logic [7:0] t3_bytes [8];
  logic [9:0] frame;
  bit         ok;
  int         bad, act, done_n, done_at, snap_tx, snap_rx;

  initial begin
    t3_bytes = '{8'h01, 8'h10, 8'h22, 8'h32, 8'h55, 8'hAA, 8'hAB, 8'h88};
    rst_lb  = 1'b1;
    rst_dir = 1'b1;
    lb_if.i_Tx_Ready  = 1'b0;
    lb_if.i_Tx_Byte   = 8'h00;
    lb_if.i_Rx_Data   = 1'b1;
    dir_if.i_Tx_Ready = 1'b0;
    dir_if.i_Tx_Byte  = 8'h00;
    dir_if.i_Rx_Data  = 1'b1;

    // 1: reset state
    step(3);
    check("t1_lb_tx_data",   lb_if.o_Tx_Data,   1);
    check("t1_lb_tx_active", lb_if.o_Tx_Active, 0);
    check("t1_lb_tx_done",   lb_if.o_Tx_Done,   0);
    check("t1_lb_rx_done",   lb_if.o_Rx_Done,   0);
    check("t1_lb_rx_byte",   lb_if.o_Rx_Byte,   0);
    check("t1_dir_tx_data",  dir_if.o_Tx_Data,  1);
    check("t1_dir_rx_byte",  dir_if.o_Rx_Byte,  0);
    rst_lb  = 1'b0;
    rst_dir = 1'b0;
    step(5);
    check("t1_no_activity", lb_if.o_Tx_Active, 0);

    // 2: single TX frame of 0x55, bit-exact
    lb_if.i_Tx_Byte  = 8'h55;
    lb_if.i_Tx_Ready = 1'b1;
    wait_lb_active(10, ok);
    check("t2_active_seen", ok, 1);
    frame = {1'b1, 8'h55, 1'b0};
    bad = 0; act = 0; done_n = 0; done_at = -1;
    for (int c = 0; c < 10 * BIT_CLKS; c++) begin
      if (lb_if.o_Tx_Data !== frame[c / BIT_CLKS]) bad++;
      if (lb_if.o_Tx_Active === 1'b1) act++;
      if (lb_if.o_Tx_Done === 1'b1) begin
        done_n++;
        done_at = c;
      end
      step(1);
    end
    check("t2_line_errors",  bad,     0);
    check("t2_active_clks",  act,     2170);
    check("t2_done_pulses",  done_n,  1);
    check("t2_done_cycle",   done_at, 2169);
    check("t2_idle_gap",     lb_if.o_Tx_Active, 0);
    check("t2_idle_line",    lb_if.o_Tx_Data,   1);
    check("t2_loop_rx_byte", lb_if.o_Rx_Byte,   8'h55);
    step(1);
    check("t2_back_to_back", lb_if.o_Tx_Active, 1);
    lb_if.i_Tx_Ready = 1'b0;
    rst_lb = 1'b1;
    step(2);
    rst_lb = 1'b0;
    step(2);

    // 3: loopback stream, next byte presented after each RX completion
    snap_tx = n_tx_lb;
    snap_rx = n_rx_lb;
    lb_if.i_Tx_Byte  = t3_bytes[0];
    lb_if.i_Tx_Ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wait_lb_rx_done(3000, ok);
      check($sformatf("t3_rx_done_%0d", i), ok, 1);
      check($sformatf("t3_rx_byte_%0d", i), lb_if.o_Rx_Byte, t3_bytes[i]);
      if (i < 7) lb_if.i_Tx_Byte = t3_bytes[i + 1];
      else       lb_if.i_Tx_Ready = 1'b0;
    end
    step(3000);
    check("t3_rx_pulses", n_rx_lb - snap_rx, 8);
    check("t3_tx_pulses", n_tx_lb - snap_tx, 8);
    check("t3_idle_end",  lb_if.o_Tx_Active, 0);

    // 4: direct RX of 0xA5
    snap_rx = n_rx_dir;
    send_dir(8'hA5, 1'b1);
    step(300);
    check("t4_rx_byte",   dir_if.o_Rx_Byte,    8'hA5);
    check("t4_rx_pulses", n_rx_dir - snap_rx,  1);

    // 5: glitch, then framing error, then recovery
    dir_if.i_Rx_Data = 1'b0;
    step(50);
    dir_if.i_Rx_Data = 1'b1;
    step(2000);
    check("t5_glitch_pulses", n_rx_dir - snap_rx, 1);
    check("t5_glitch_byte",   dir_if.o_Rx_Byte,   8'hA5);
    send_dir(8'h3C, 1'b0);
    step(500);
    check("t5_frame_err_pulses", n_rx_dir - snap_rx, 1);
    check("t5_frame_err_byte",   dir_if.o_Rx_Byte,   8'hA5);
    send_dir(8'h5A, 1'b1);
    step(300);
    check("t5_recover_byte",   dir_if.o_Rx_Byte,   8'h5A);
    check("t5_recover_pulses", n_rx_dir - snap_rx, 2);

    // 6: reset during D3 of a 0x07 frame (D3 = 0)
    lb_if.i_Tx_Byte  = 8'h07;
    lb_if.i_Tx_Ready = 1'b1;
    wait_lb_active(10, ok);
    check("t6_active_seen", ok, 1);
    step(4 * BIT_CLKS + 100);
    check("t6_d3_line",   lb_if.o_Tx_Data,   0);
    check("t6_d3_active", lb_if.o_Tx_Active, 1);
    snap_tx = n_tx_lb;
    rst_lb = 1'b1;
    step(1);
    check("t6_abort_line",   lb_if.o_Tx_Data,   1);
    check("t6_abort_active", lb_if.o_Tx_Active, 0);
    step(3);
    check("t6_req_in_reset", lb_if.o_Tx_Active, 0);
    lb_if.i_Tx_Ready = 1'b0;
    rst_lb = 1'b0;
    step(3000);
    check("t6_no_done", n_tx_lb - snap_tx, 0);
    check("t6_quiet",   lb_if.o_Tx_Data,   1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
